// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter granting whole-block bursts to one cache at a time
// Define BUS_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module bus_arbiter #(
    parameter  int num_caches_p     = 2,
    parameter  int block_width_p    = 8,
    parameter  int dma_data_width_p = 2,
    localparam int data_width_lp    = 32 * dma_data_width_p,
    localparam int pkt_width_lp     = 33 + data_width_lp,
    localparam int grant_width_lp   = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
    input  logic                                        clk_i,
    input  logic                                        nreset_i,
    input  logic [num_caches_p-1:0]                     cb_valid_i,
    output logic [num_caches_p-1:0]                     cb_yumi_o,
    // each packet is packed as {addr[31:0], wdata[D-1:0], we}
    input  logic [num_caches_p-1:0][pkt_width_lp-1:0]   cb_pkt_i,
    input  logic                                        mem_ready_i,
    output logic                                        mem_valid_o,
    output logic                                        mem_we_o,
    output logic [31:0]                                 mem_addr_o,
    output logic [data_width_lp-1:0]                    mem_wdata_o,
    input  logic                                        mem_valid_i,
    input  logic [data_width_lp-1:0]                    mem_data_i,
    output logic [num_caches_p-1:0]                     cb_valid_o,
    output logic [data_width_lp-1:0]                    cb_data_o,
    output logic [grant_width_lp-1:0]                   grant_id_o,
    output logic                                        busy_o
);

    localparam int beats_lp     = block_width_p / dma_data_width_p;
    localparam int cnt_width_lp = $clog2(beats_lp + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [grant_width_lp-1:0] grant_q, grant_d;
    logic [cnt_width_lp-1:0]   beat_cnt_q, beat_cnt_d;
    logic [cnt_width_lp-1:0]   resp_cnt_q, resp_cnt_d;
    logic                      we_q, we_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
    logic [grant_width_lp-1:0] last_grant_q, last_grant_d;
`endif

    logic [pkt_width_lp-1:0]   sel_pkt;
    logic [31:0]               sel_addr;
    logic [data_width_lp-1:0]  sel_wdata;
    logic                      sel_we;
    logic [num_caches_p-1:0]   grant_oh;
    logic [grant_width_lp-1:0] winner;
    logic                      accept;
    logic                      resp_fire;
    logic [cnt_width_lp-1:0]   resp_cnt_next;
    logic                      burst_we;
    logic                      go_idle;

    assign sel_pkt   = cb_pkt_i[grant_q];
    assign sel_addr  = sel_pkt[pkt_width_lp-1 -: 32];
    assign sel_wdata = sel_pkt[data_width_lp:1];
    assign sel_we    = sel_pkt[0];

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // Winner search; only consulted while IDLE.
    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
`ifdef BUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < num_caches_p; i++) begin
            if (!found && cb_valid_i[i]) begin
                winner = grant_width_lp'(i);
                found  = 1'b1;
            end
        end
`else
        for (int i = 1; i <= num_caches_p; i++) begin
            idx = (int'(last_grant_q) + i) % num_caches_p;
            if (!found && cb_valid_i[idx]) begin
                winner = grant_width_lp'(idx);
                found  = 1'b1;
            end
        end
`endif
    end

    assign mem_valid_o   = (state_q == XFER) & cb_valid_i[grant_q];
    assign accept        = mem_valid_o & mem_ready_i;
    // Responses beyond the expected count, or outside a burst, are dropped.
    assign resp_fire     = mem_valid_i & (state_q != IDLE)
                         & (resp_cnt_q != cnt_width_lp'(beats_lp));
    assign resp_cnt_next = resp_cnt_q + cnt_width_lp'(resp_fire);
    // The first beat's we defines the burst; later beats use the latched copy.
    assign burst_we      = (beat_cnt_q == '0) ? sel_we : we_q;

    assign mem_we_o    = (state_q == XFER) & sel_we;
    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;
    assign cb_yumi_o   = grant_oh & {num_caches_p{accept}};
    assign cb_valid_o  = grant_oh & {num_caches_p{resp_fire}};
    assign cb_data_o   = mem_data_i;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        we_d         = we_q;
        go_idle      = 1'b0;
`ifndef BUS_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (|cb_valid_i) begin
                    state_d = XFER;
                    grant_d = winner;
                end
            end
            XFER: begin
                resp_cnt_d = resp_cnt_next;
                if (accept) begin
                    if (beat_cnt_q == '0) begin
                        we_d = sel_we;
                    end
                    if (beat_cnt_q == cnt_width_lp'(beats_lp - 1)) begin
                        if (burst_we || (resp_cnt_next == cnt_width_lp'(beats_lp))) begin
                            go_idle = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
                    end
                end
            end
            DRAIN: begin
                resp_cnt_d = resp_cnt_next;
                if (resp_cnt_next == cnt_width_lp'(beats_lp)) begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_idle) begin
            state_d      = IDLE;
            beat_cnt_d   = '0;
            resp_cnt_d   = '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_grant_d = grant_q;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            resp_cnt_q   <= '0;
            we_q         <= 1'b0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_grant_q <= grant_width_lp'(num_caches_p - 1);
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            we_q         <= we_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shared-bus arbiter between `num_caches_p` private caches and a single memory port. It replaces the single-cache pass-through bus. It grants the bus to one cache for a whole block transfer of `block_width_p / dma_data_width_p` beats. It forwards that cache's request beats to memory and routes memory response beats back only to the granted cache. It then rotates priority so that no cache starves.

## Interface
Parameters:
- `num_caches_p`, 2: number of caches; must be ≥ 1.
- `block_width_p`, 8: words per cache block.
- `dma_data_width_p`, 2: words per bus beat; must divide `block_width_p`. BEATS = `block_width_p / dma_data_width_p`.
- Data width D = 32·`dma_data_width_p` bits. Grant width G = max(1, clog2(`num_caches_p`)).

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `nreset_i` in 1: reset, asynchronous and active-low.
- `cb_valid_i` in N: per-cache request beat valid.
- `cb_yumi_o` out N: per-cache beat accepted this cycle.
- `cb_pkt_i` in N×`cache_bus_pkt_t`: per-cache beat with fields `addr` (32), `wdata` (D) and `we` (1).
- `mem_ready_i` in 1: memory can accept a beat.
- `mem_valid_o` out 1: a beat is presented to memory.
- `mem_we_o` out 1, `mem_addr_o` out 32, `mem_wdata_o` out D: the beat fields.
- `mem_valid_i` in 1, `mem_data_i` in D: read response beat.
- `cb_valid_o` out N: one-hot response valid.
- `cb_data_o` out D: response data, broadcast to all caches.
- `grant_id_o` out G: index of the cache that owns the bus.
- `busy_o` out 1: the arbiter is not in IDLE.

## Operation
- FSM states:
  - IDLE: no owner.
  - XFER: forwarding request beats.
  - DRAIN: all request beats sent, waiting for read responses.
- IDLE → XFER: taken when any `cb_valid_i` is set.
  - The winner is registered into `grant_id_o`. No beat is accepted in this cycle.
- Round-robin: search starts at index (last_grant+1) mod N and wraps around. The first valid cache wins.
- XFER:
  - `mem_valid_o` = `cb_valid_i[grant]`.
  - `mem_*` fields come from `cb_pkt_i[grant]`.
  - `cb_yumi_o[grant]` = `mem_ready_i & mem_valid_o`. All other yumi bits are 0.
  - Requests from non-granted caches are held off and receive no yumi.
- The burst direction is latched from `we` of the first accepted beat. Later beats are assumed to have the same `we`; this is not checked.
- The beat counter counts accepted beats, from 0 to BEATS-1. When the last beat is accepted:
  - For a write burst, the next state is IDLE.
  - For a read burst, the next state is IDLE if all BEATS responses have already been received. Otherwise the next state is DRAIN.
- The response counter counts `mem_valid_i` pulses in XFER and DRAIN.
- `cb_valid_o` = onehot(grant) & {N{`mem_valid_i`}}, valid in XFER and DRAIN only.
- `cb_data_o` = `mem_data_i` at all times.
- DRAIN → IDLE: taken on the cycle the response counter reaches BEATS.
- On return to IDLE, last_grant is set to the current grant and both counters are cleared.
- `cb_valid_i[grant]` dropping mid-burst does not release the grant.
- A `mem_valid_i` pulse in IDLE, or an extra pulse after BEATS responses, is dropped: `cb_valid_o` stays 0.
- With `num_caches_p`=1, behaviour is identical except that the grant is always 0.

## Timing
- Reset values:
  - State IDLE, `grant_id_o`=0, last_grant=N-1 so that cache 0 has first priority.
  - Counters 0.
  - `cb_yumi_o`, `cb_valid_o`, `mem_valid_o`, `mem_we_o` and `busy_o` all 0.
- Reset asserted mid-burst aborts the burst immediately. In-flight responses after reset are dropped.
- Grant latency: 1 cycle from `cb_valid_i` rising in IDLE to the first possible yumi.
- The request path is combinational: from `cb_valid_i`/`mem_ready_i` to `mem_valid_o`/`cb_yumi_o`.
- The response path is combinational: from `mem_valid_i` to `cb_valid_o`, with 0 cycles added.
- At most one beat is accepted per cycle. A response and a request acceptance may occur in the same cycle.
- Minimum back-to-back burst gap: 1 IDLE cycle between owners.

## Configuration
- `BUS_ARB_FIXED_PRIO_EN`:
  - When defined, arbitration is fixed priority and the lowest valid index always wins. last_grant is unused.
  - When undefined, arbitration is round-robin as above.

## Test plan
- Reset with BEATS=4, N=2: cache0 writes 4 beats to `addr` 0x100..0x10C with `mem_ready_i`=1 → `grant_id_o`=0. One yumi per cycle for cycles 2-5, then IDLE. `mem_wdata_o` matches each packet.
- Both caches request continuously → grants alternate 0,1,0,1. With `BUS_ARB_FIXED_PRIO_EN`, cache 0 is granted every burst.
- Cache1 read: 4 beats accepted, responses arrive 3 cycles later with data 0xA0..0xA3 → only `cb_valid_o[1]` pulses 4 times. State is DRAIN until the 4th pulse, then IDLE.
- `mem_ready_i` toggles 1/0 during a write burst → yumi only on ready cycles. The beat count still completes at 4. Cache0 is never yumi'd while cache1 owns the bus.
- Spurious `mem_valid_i` in IDLE → `cb_valid_o`=0. Reset asserted after 2 read beats → all outputs return to reset values asynchronously, and the next request is granted to cache 0.
